// File: rtl/alu_op_scheduler.sv
// ALU operation sequencer: walks a snapshot op mask, launches one ALU op
// per set bit and paces each op on the UART transmitter busy handshake.
module alu_op_scheduler #(
  parameter int NUM_OPS     = 16,
  parameter int FUN_WD      = 4,
  parameter int TIMEOUT_CYC = 255,
  parameter int TO_WD       = 8
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               Start,
  input  logic [NUM_OPS-1:0] Op_Mask,
  input  logic               Continuous,
  input  logic               UART_Busy,
  output logic [FUN_WD-1:0]  ALU_FUN,
  output logic               ALU_Enable,
  output logic               CLKG_EN,
  output logic               Busy,
  output logic               Done,
  output logic               Timeout_Err
);

  localparam int IDX_WD = $clog2(NUM_OPS);
  localparam logic [IDX_WD-1:0] LAST_IDX =
    IDX_WD'(NUM_OPS - 1);
  localparam logic [TO_WD-1:0] TO_LAST =
    TO_WD'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN,
    S_ISSUE,
    S_WAIT_HIGH,
    S_WAIT_LOW,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_WD-1:0]  idx_q, idx_d;
  logic [NUM_OPS-1:0] mask_q, mask_d;
  logic [TO_WD-1:0]   to_cnt_q, to_cnt_d;
  logic               err_q, err_d;
  logic               adv;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      mask_q   <= '0;
      to_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      mask_q   <= mask_d;
      to_cnt_q <= to_cnt_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    mask_d   = mask_q;
    to_cnt_d = to_cnt_q;
    err_d    = err_q;
    adv      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (Start) begin
          mask_d  = Op_Mask;
          idx_d   = '0;
          err_d   = 1'b0;
          state_d = S_SCAN;
        end
      end
      S_SCAN: begin
        if (mask_q[idx_q]) begin
          state_d = S_ISSUE;
        end else if (idx_q == LAST_IDX) begin
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_ISSUE: begin
        to_cnt_d = '0;
        state_d  = S_WAIT_HIGH;
      end
      S_WAIT_HIGH: begin
        if (UART_Busy) begin
          state_d = S_WAIT_LOW;
        end else if (to_cnt_q == TO_LAST) begin
          err_d = 1'b1;
          adv   = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      S_WAIT_LOW: begin
        if (!UART_Busy) adv = 1'b1;
      end
      S_DONE: begin
        // Repeat mode re-snapshots the mask but keeps the error sticky
        if (Continuous) begin
          mask_d  = Op_Mask;
          idx_d   = '0;
          state_d = S_SCAN;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (adv) begin
      if (idx_q == LAST_IDX) begin
        state_d = S_DONE;
      end else begin
        idx_d   = idx_q + 1'b1;
        state_d = S_SCAN;
      end
    end
  end

  assign ALU_Enable  = (state_q == S_ISSUE);
  assign ALU_FUN     = ALU_Enable ? FUN_WD'(idx_q) : '0;
  assign CLKG_EN     = (state_q != S_WAIT_LOW);
  assign Busy        = (state_q != S_IDLE);
  assign Done        = (state_q == S_DONE);
  assign Timeout_Err = err_q;

endmodule

// File: tb/tb_alu_op_scheduler.sv
// Scoreboard bench for alu_op_scheduler: expected strobe/done events are
// queued per pass from the mask; a monitor pops and compares them.
module tb_alu_op_scheduler;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        Start = 1'b0;
  logic [15:0] Op_Mask = '0;
  logic        Continuous = 1'b0;
  logic        UART_Busy = 1'b0;
  logic [3:0]  ALU_FUN;
  logic        ALU_Enable;
  logic        CLKG_EN;
  logic        Busy;
  logic        Done;
  logic        Timeout_Err;

  alu_op_scheduler dut (
    .CLK        (CLK),
    .RST        (RST),
    .Start      (Start),
    .Op_Mask    (Op_Mask),
    .Continuous (Continuous),
    .UART_Busy  (UART_Busy),
    .ALU_FUN    (ALU_FUN),
    .ALU_Enable (ALU_Enable),
    .CLKG_EN    (CLKG_EN),
    .Busy       (Busy),
    .Done       (Done),
    .Timeout_Err(Timeout_Err)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_err    = 0;
  int exp_q[$];
  int model_err = 0;
  int uart_on = 0;
  int u_rand  = 0;
  int ud = 0;
  int uh = 1;
  int done_cnt = 0;
  int strobe_cnt = 0;
  int clkg0_cnt = 0;
  logic busy_prev = 1'b0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d",
               nm, act, expv);
    end
  endtask

  // Done event carries the expected sticky error as 100+err
  function automatic void push_pass(input logic [15:0] m);
    for (int i = 0; i < 16; i++)
      if (m[i]) exp_q.push_back(i);
    if (uart_on == 0 && m != 0) model_err = 1;
    exp_q.push_back(100 + model_err);
  endfunction

  always @(negedge CLK) begin
    int e;
    if (RST) begin
      if (ALU_Enable) begin
        e = (exp_q.size() != 0) ? exp_q.pop_front() : -1;
        chk("alu_fun", 32'(ALU_FUN), e);
        strobe_cnt++;
      end else begin
        chk("fun_idle_zero", 32'(ALU_FUN), 0);
      end
      if (Done) begin
        e = (exp_q.size() != 0) ? exp_q.pop_front() : -1;
        chk("done_evt", 100 + 32'(Timeout_Err), e);
        done_cnt++;
        if (Continuous) push_pass(Op_Mask);
      end
      if (!CLKG_EN) begin
        chk("clkg_only_when_busy", 32'(busy_prev), 1);
        clkg0_cnt++;
      end
    end
    busy_prev = UART_Busy;
  end

  // UART transmitter model: busy window follows each ALU strobe
  initial begin
    int d;
    int h;
    forever begin
      @(negedge CLK);
      if (RST && ALU_Enable && uart_on != 0) begin
        d = u_rand ? int'($urandom_range(0, 3)) : ud;
        h = u_rand ? int'($urandom_range(1, 5)) : uh;
        repeat (d + 1) @(posedge CLK);
        #1 UART_Busy = 1'b1;
        repeat (h) @(posedge CLK);
        #1 UART_Busy = 1'b0;
      end
    end
  end

  task automatic do_start(input logic [15:0] m);
    Op_Mask = m;
    model_err = 0;
    push_pass(m);
    @(posedge CLK);
    #1 Start = 1'b1;
    @(posedge CLK);
    #1 Start = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    int base = done_cnt;
    int k = 0;
    while (done_cnt == base && k < bound) begin
      @(posedge CLK);
      k++;
    end
    chk("done_seen", done_cnt - base, 1);
  endtask

  task automatic wait_idle(input int bound);
    int k = 0;
    @(negedge CLK);
    while (Busy && k < bound) begin
      @(negedge CLK);
      k++;
    end
    chk("idle_reached", 32'(Busy), 0);
  endtask

  initial begin
    int n;
    int s0;
    int c0;
    logic [15:0] rm;

    #12;
    chk("rst_fun", 32'(ALU_FUN), 0);
    chk("rst_en", 32'(ALU_Enable), 0);
    chk("rst_clkg", 32'(CLKG_EN), 1);
    chk("rst_busy", 32'(Busy), 0);
    chk("rst_done", 32'(Done), 0);
    chk("rst_err", 32'(Timeout_Err), 0);
    @(posedge CLK);
    #1 RST = 1'b1;

    // two ops paced by UART busy
    uart_on = 1; u_rand = 0; ud = 1; uh = 10;
    s0 = strobe_cnt; c0 = clkg0_cnt;
    do_start(16'h0005);
    wait_done(400);
    wait_idle(10);
    chk("t1_strobes", strobe_cnt - s0, 2);
    chk("t1_gated", 32'(clkg0_cnt > c0), 1);
    chk("t1_err", 32'(Timeout_Err), 0);

    // empty mask: Done exactly in cycle 17
    do_start(16'h0000);
    n = 1;
    @(negedge CLK);
    while (!Done && n < 40) begin
      @(negedge CLK);
      n++;
    end
    chk("t2_done_cycle", n, 17);
    wait_idle(10);

    // timeout on the last op
    uart_on = 0;
    c0 = clkg0_cnt;
    do_start(16'h8000);
    n = 0;
    @(negedge CLK);
    while (!ALU_Enable && n < 40) begin
      @(negedge CLK);
      n++;
    end
    chk("t3_strobe_seen", 32'(ALU_Enable), 1);
    chk("t3_fun", 32'(ALU_FUN), 15);
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!Done && n < 400);
    chk("t3_timeout_lat", n, 256);
    chk("t3_err_set", 32'(Timeout_Err), 1);
    chk("t3_clkg_never", clkg0_cnt - c0, 0);
    wait_idle(10);
    chk("t3_err_sticky", 32'(Timeout_Err), 1);
    do_start(16'h0000);
    @(negedge CLK);
    chk("t3_err_cleared", 32'(Timeout_Err), 0);
    wait_done(40);
    wait_idle(10);

    // mask snapshot and ignored mid-pass Start
    uart_on = 1; ud = 0; uh = 4;
    do_start(16'h0003);
    n = 0;
    @(negedge CLK);
    while (!ALU_Enable && n < 40) begin
      @(negedge CLK);
      n++;
    end
    @(posedge CLK);
    #1 Op_Mask = 16'h0000;
    Start = 1'b1;
    repeat (3) @(posedge CLK);
    #1 Start = 1'b0;
    wait_done(400);
    wait_idle(10);
    repeat (3) @(negedge CLK);
    chk("t4_stays_idle", 32'(Busy), 0);

    // continuous mode, dropped mid-pass
    Continuous = 1'b1;
    s0 = done_cnt;
    do_start(16'h0001);
    n = 0;
    while (done_cnt - s0 < 3 && n < 500) begin
      @(posedge CLK);
      n++;
    end
    #1 Continuous = 1'b0;
    wait_idle(200);
    chk("t5_passes", done_cnt - s0, 4);

    // async reset in WAIT_LOW
    ud = 0; uh = 12;
    do_start(16'h0001);
    n = 0;
    @(negedge CLK);
    while (CLKG_EN && n < 40) begin
      @(negedge CLK);
      n++;
    end
    chk("t6_in_wait_low", 32'(CLKG_EN), 0);
    #2 RST = 1'b0;
    #1;
    chk("t6_rst_clkg", 32'(CLKG_EN), 1);
    chk("t6_rst_busy", 32'(Busy), 0);
    chk("t6_rst_en", 32'(ALU_Enable), 0);
    exp_q.delete();
    repeat (20) @(posedge CLK);
    #1 RST = 1'b1;
    uh = 3;
    do_start(16'h0003);
    wait_done(400);
    wait_idle(10);

    // randomized passes
    u_rand = 1;
    for (int r = 0; r < 6; r++) begin
      rm = 16'($urandom_range(0, 65535));
      do_start(rm);
      wait_done(3000);
      wait_idle(10);
      chk("rand_err", 32'(Timeout_Err), 0);
    end

    repeat (2) @(negedge CLK);
    chk("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1);
  end

endmodule
